// File: rtl/stfq_rank_tagger.sv
// Start-Time Fair Queuing rank tagger placed in front of a register-based PIFO.
// It looks up a per-flow finish tag and takes the larger of that tag and the
// virtual clock as the start tag, which becomes the PIFO rank. The new finish
// tag (start + length, clamped to the top of the rank range) is written back.
// The virtual clock only moves forward, driven by the ranks leaving the PIFO.
module stfq_rank_tagger #(
  parameter int NUM_FLOWS  = 16,
  parameter int FLOW_W     = 4,
  parameter int LEN_W      = 11,
  parameter int RANK_W     = 16,
  parameter int META_W     = 12,
  parameter int PIFO_DEPTH = 16,
  parameter int CNT_W      = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FLOW_W-1:0] in_flow,
  input  logic [LEN_W-1:0]  in_len,
  input  logic [META_W-1:0] in_meta,
  output logic              pifo_insert,
  output logic [RANK_W-1:0] pifo_rank,
  output logic [META_W-1:0] pifo_meta,
  input  logic [CNT_W-1:0]  pifo_num_entries,
  input  logic              deq_fire,
  input  logic [RANK_W-1:0] deq_rank,
  output logic [RANK_W-1:0] vtime,
  output logic [7:0]        sat_count
);

  localparam logic [RANK_W-1:0] RANK_MAX  = '1;
  localparam logic [CNT_W:0]    DEPTH_C   = (CNT_W+1)'(PIFO_DEPTH);
  localparam logic [7:0]        SAT_MAX   = 8'hFF;

  // The finish tags must be cleared on reset, so they live in flops rather
  // than block RAM; the lookup is also needed in the same cycle as the accept.
  logic [RANK_W-1:0] finish_q [NUM_FLOWS];

  logic              insert_q;
  logic [RANK_W-1:0] rank_q;
  logic [META_W-1:0] meta_q;
  logic [RANK_W-1:0] vtime_q;
  logic [RANK_W-1:0] vtime_d;
  logic [7:0]        sat_q;
  logic [7:0]        sat_d;

  logic [CNT_W:0]    occupancy;
  logic              accept;
  logic [RANK_W-1:0] cur_finish;
  logic [RANK_W-1:0] start_tag;
  logic [RANK_W:0]   sum_tag;
  logic              saturated;
  logic [RANK_W-1:0] finish_new;

  // Backpressure counts the insert already in flight and ignores dequeues,
  // so the PIFO can never be overfilled.
  always_comb begin
    occupancy = {1'b0, pifo_num_entries} + {{CNT_W{1'b0}}, insert_q};
    in_ready  = !rst && (occupancy < DEPTH_C);
    accept    = in_valid && in_ready;
  end

  // Start/finish tag arithmetic from registered state; the extra sum bit
  // detects overflow of the rank range, which clamps instead of wrapping.
  always_comb begin
    cur_finish = finish_q[in_flow];
    start_tag  = (cur_finish > vtime_q) ? cur_finish : vtime_q;
    sum_tag    = {1'b0, start_tag} + {{(RANK_W+1-LEN_W){1'b0}}, in_len};
    saturated  = sum_tag[RANK_W];
    finish_new = saturated ? RANK_MAX : sum_tag[RANK_W-1:0];
  end

  // Next virtual time (monotonic) and next saturation count (sticks at 255).
  always_comb begin
    vtime_d = vtime_q;
    if (deq_fire && (deq_rank > vtime_q)) begin
      vtime_d = deq_rank;
    end
    sat_d = sat_q;
    if (accept && saturated && (sat_q != SAT_MAX)) begin
      sat_d = sat_q + 8'd1;
    end
  end

  // One writer per table entry; a same-flow descriptor in the next cycle sees
  // the updated tag because the write lands at the edge before its lookup.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_FLOWS; gi++) begin : g_finish
      always_ff @(posedge clk) begin
        if (rst) begin
          finish_q[gi] <= '0;
        end else if (accept && (in_flow == FLOW_W'(gi))) begin
          finish_q[gi] <= finish_new;
        end
      end
    end
  endgenerate

  // Insert port, virtual clock and saturation counter; a reset drops any
  // pending insert.
  always_ff @(posedge clk) begin
    if (rst) begin
      insert_q <= 1'b0;
      rank_q   <= '0;
      meta_q   <= '0;
      vtime_q  <= '0;
      sat_q    <= '0;
    end else begin
      insert_q <= accept;
      if (accept) begin
        rank_q <= start_tag;
        meta_q <= in_meta;
      end
      vtime_q <= vtime_d;
      sat_q   <= sat_d;
    end
  end

  assign pifo_insert = insert_q;
  assign pifo_rank   = rank_q;
  assign pifo_meta   = meta_q;
  assign vtime       = vtime_q;
  assign sat_count   = sat_q;

endmodule

// File: tb/tb_stfq_rank_tagger.sv
// Bench for stfq_rank_tagger: a table of descriptors with expected ranks plus
// hand-written sequences for the virtual clock, backpressure, saturation and
// reset. Expected inserts go into a scoreboard queue tagged with the cycle in
// which they must appear; a monitor compares every cycle.
module tb_stfq_rank_tagger;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_flow;
  logic [10:0] in_len;
  logic [11:0] in_meta;
  logic        pifo_insert;
  logic [15:0] pifo_rank;
  logic [11:0] pifo_meta;
  logic [4:0]  pifo_num_entries;
  logic        deq_fire;
  logic [15:0] deq_rank;
  logic [15:0] vtime;
  logic [7:0]  sat_count;

  stfq_rank_tagger dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_flow          (in_flow),
    .in_len           (in_len),
    .in_meta          (in_meta),
    .pifo_insert      (pifo_insert),
    .pifo_rank        (pifo_rank),
    .pifo_meta        (pifo_meta),
    .pifo_num_entries (pifo_num_entries),
    .deq_fire         (deq_fire),
    .deq_rank         (deq_rank),
    .vtime            (vtime),
    .sat_count        (sat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] rank;
    logic [11:0] meta;
    int          due;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic [3:0]  flow;
    logic [10:0] len;
    logic [11:0] meta;
    logic [15:0] rank;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end else begin
      $display("ok   %s: %0d", name, actual);
    end
  endtask

  // Every cycle: either the scoreboard head is due now and must match the
  // insert port, or no insert may be present.
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].due == cyc) begin
      checks++;
      if (pifo_insert !== 1'b1 || pifo_rank !== sb[0].rank || pifo_meta !== sb[0].meta) begin
        errors++;
        $display("FAIL insert@%0d: got ins=%0b rank=%0d meta=%0h expected ins=1 rank=%0d meta=%0h",
                 cyc, pifo_insert, pifo_rank, pifo_meta, sb[0].rank, sb[0].meta);
      end else begin
        $display("ok   insert@%0d: rank=%0d meta=%0h", cyc, pifo_rank, pifo_meta);
      end
      void'(sb.pop_front());
    end else if (pifo_insert !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL idle@%0d: got ins=%0b expected ins=0", cyc, pifo_insert);
    end
  end

  // Present one descriptor at the current falling edge; if it will be
  // accepted at the coming rising edge, expect its insert one cycle later.
  task automatic send(input logic [3:0] flow, input logic [10:0] len,
                      input logic [11:0] meta, input logic [15:0] rank);
    exp_t e;
    in_valid = 1'b1;
    in_flow  = flow;
    in_len   = len;
    in_meta  = meta;
    #1;
    if (in_ready) begin
      e.rank = rank;
      e.meta = meta;
      e.due  = cyc + 1;
      sb.push_back(e);
    end else begin
      checks++;
      errors++;
      $display("FAIL accept flow %0d: got in_ready=0 expected 1", flow);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic deq(input logic [15:0] r);
    deq_fire = 1'b1;
    deq_rank = r;
    @(negedge clk);
    deq_fire = 1'b0;
  endtask

  initial begin
    // Ranks with all tags and the virtual clock starting at 0.
    vecs[0]  = '{4'd3, 11'd100,  12'h0AB, 16'd0};
    vecs[1]  = '{4'd3, 11'd100,  12'h001, 16'd100};
    vecs[2]  = '{4'd3, 11'd100,  12'h002, 16'd200};
    vecs[3]  = '{4'd3, 11'd100,  12'h003, 16'd300};
    vecs[4]  = '{4'd1, 11'd50,   12'h011, 16'd0};
    vecs[5]  = '{4'd2, 11'd50,   12'h022, 16'd0};
    vecs[6]  = '{4'd1, 11'd50,   12'h013, 16'd50};
    vecs[7]  = '{4'd2, 11'd50,   12'h024, 16'd50};
    vecs[8]  = '{4'd3, 11'd0,    12'h030, 16'd400};
    vecs[9]  = '{4'd3, 11'd5,    12'h031, 16'd400};
    vecs[10] = '{4'd3, 11'd1,    12'h032, 16'd405};
    vecs[11] = '{4'd4, 11'd2047, 12'hFFF, 16'd0};
    vecs[12] = '{4'd4, 11'd1,    12'h040, 16'd2047};
    vecs[13] = '{4'd15, 11'd7,   12'h0F0, 16'd0};

    rst = 1'b1;
    in_valid = 1'b0;
    in_flow = '0;
    in_len = '0;
    in_meta = '0;
    pifo_num_entries = '0;
    deq_fire = 1'b0;
    deq_rank = '0;

    repeat (3) @(negedge clk);
    check("reset_in_ready", in_ready, 0);
    check("reset_insert", pifo_insert, 0);
    check("reset_rank", pifo_rank, 0);
    check("reset_meta", pifo_meta, 0);
    check("reset_vtime", vtime, 0);
    check("reset_sat", sat_count, 0);
    rst = 1'b0;
    #1;
    check("ready_after_reset", in_ready, 1);
    @(negedge clk);

    // Back-to-back table vectors, one per cycle.
    for (int i = 0; i < 14; i++) begin
      send(vecs[i].flow, vecs[i].len, vecs[i].meta, vecs[i].rank);
    end
    idle(2);

    // Virtual clock advanced by a dequeue; a lower rank does not move it back.
    deq(16'd500);
    check("vtime_500", vtime, 500);
    send(4'd5, 11'd10, 12'h050, 16'd500);
    idle(1);
    deq(16'd300);
    check("vtime_monotonic", vtime, 500);

    // Dequeue and accept together: rank uses the old virtual time.
    deq_fire = 1'b1;
    deq_rank = 16'd600;
    send(4'd6, 11'd10, 12'h060, 16'd500);
    deq_fire = 1'b0;
    in_valid = 1'b0;
    check("vtime_same_cycle", vtime, 600);
    idle(1);

    // Backpressure at the capacity boundary.
    pifo_num_entries = 5'd15;
    #1;
    check("ready_15_no_pending", in_ready, 1);
    send(4'd7, 11'd1, 12'h070, 16'd600);
    #1;
    check("ready_15_pending", in_ready, 0);
    in_valid = 1'b0;
    pifo_num_entries = 5'd16;
    in_valid = 1'b1;
    in_flow = 4'd8;
    @(negedge clk);
    #1;
    check("ready_16", in_ready, 0);
    @(negedge clk);
    check("no_insert_16", pifo_insert, 0);
    in_valid = 1'b0;
    pifo_num_entries = 5'd0;
    @(negedge clk);

    // Finish-tag saturation.
    deq(16'd65500);
    check("vtime_65500", vtime, 65500);
    send(4'd0, 11'd100, 12'h0A0, 16'd65500);
    check("sat_count_1", sat_count, 1);
    send(4'd0, 11'd0, 12'h0A1, 16'd65535);
    check("sat_exact_max", sat_count, 1);
    send(4'd0, 11'd1, 12'h0A2, 16'd65535);
    check("sat_count_2", sat_count, 2);

    // Reset while an insert is showing and another descriptor is offered.
    in_valid = 1'b1;
    in_flow = 4'd2;
    in_len = 11'd3;
    rst = 1'b1;
    #1;
    check("ready_in_reset", in_ready, 0);
    @(negedge clk);
    check("drop_insert", pifo_insert, 0);
    check("vtime_after_rst", vtime, 0);
    check("sat_after_rst", sat_count, 0);
    rst = 1'b0;
    send(4'd0, 11'd10, 12'h0B0, 16'd0);
    send(4'd2, 11'd3, 12'h0B1, 16'd0);
    idle(3);

    check("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
